dct_transpose_buffer: RTL

- Ping-pong block buffer between the row-DCT stage and the column-DCT stage.
- Accepts one N×N block (N = 2^(K/2)) of row-transform coefficients in row-major order.
- Replays each completed block in column-major (transposed) order.
- Its write/read position counters are up-counters with the same 6-bit default width as the block-index counters used elsewhere in the DCT datapath, so it sits directly downstream of the row stage's sample counter.

---
 rtl/dct_pkg.sv | 12 +
 rtl/dct_tb_bank.sv | 18 +
 rtl/dct_transpose_buffer.sv | 77 +++++++
 3 files changed

// File: rtl/dct_pkg.sv
// dct_pkg: shared DCT constants and the block transpose index helper
package dct_pkg;
  localparam int W_DEF = 12;
  localparam int K_DEF = 6;
  localparam int N = 2 ** (K_DEF / 2);
  localparam int BLK = 2 ** K_DEF;
  function automatic logic [31:0] transpose_idx(input logic [31:0] idx, input int k);
    logic [31:0] m;
    m = (32'd1 << (k / 2)) - 32'd1;
    return ((idx & m) << (k / 2)) | ((idx >> (k / 2)) & m);
  endfunction
endpackage

// File: rtl/dct_tb_bank.sv
// dct_tb_bank: one 2^K x W register bank, sync write port, combinational read port
// ports: clk, we/waddr/wdata write port, raddr/rdata read port
module dct_tb_bank #(
  parameter int W = 12,
  parameter int K = 6
) (
  input  logic         clk,
  input  logic         we,
  input  logic [K-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic [K-1:0] raddr,
  output logic [W-1:0] rdata
);
  logic [W-1:0] mem [2**K];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/dct_transpose_buffer.sv
// dct_transpose_buffer: ping-pong N x N block buffer, row-major in, column-major out
// ports: clk, reset (async active-low), flush (sync discard),
//        in_valid/in_data/in_ready write stream, out_valid/out_data/out_ready/out_idx/out_last read stream
module dct_transpose_buffer
  import dct_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int K = K_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [K-1:0] out_idx,
  output logic         out_last
);
  logic         wr_bank, rd_bank;
  logic [K-1:0] wr_cnt, rd_cnt, rd_addr;
  logic [1:0]   full;
  logic         acc, xfer;
  logic [W-1:0] rdata [2];
  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign out_idx   = rd_cnt;
  assign out_last  = out_valid && rd_cnt == '1;
  assign acc       = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign rd_addr   = K'(transpose_idx(32'(rd_cnt), K));
  assign out_data  = rdata[rd_bank];
  for (genvar b = 0; b < 2; b++) begin : g_bank
    dct_tb_bank #(.W(W), .K(K)) u_bank (
      .clk  (clk),
      .we   (acc && !flush && wr_bank == 1'(b)),
      .waddr(wr_cnt),
      .wdata(in_data),
      .raddr(rd_addr),
      .rdata(rdata[b])
    );
  end
  // writes only target a non-full bank and reads only a full one, so the
  // set and clear below never hit the same flag in one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      full    <= '0;
    end else if (flush) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      full    <= '0;
    end else begin
      if (acc) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_cnt == '1) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= !wr_bank;
        end
      end
      if (xfer) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (out_last) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= !rd_bank;
        end
      end
    end
  end
endmodule
